// File: rtl/image_control.sv
// ---------------------------------------------------------------------------
// image_control
//   Write/read sequencer for a bank of four external single-line buffers that
//   feed a 3x3 kernel. Incoming pixels are distributed round-robin, one whole
//   line per buffer. Once three complete lines are held, the three oldest
//   lines are read in lock-step and one 3x3 window is produced per read.
//   After each drained line a one-cycle interrupt lets upstream refill it.
//
// Parameters
//   IMG_WIDTH  pixels per line (= buffer depth), power of two, >= 4
//   PIX_W      bits per grayscale pixel
//
// Ports
//   i_clk          clock, all logic on the rising edge
//   i_rstn         asynchronous active-low reset
//   i_pixel_data   incoming pixel
//   i_pixel_valid  i_pixel_data valid this cycle
//   i_out_ready    downstream ready (only with IMGCTRL_READY_EN)
//   o_lb_data      pixel broadcast to all four buffers
//   o_lb_wr_en     one-hot write strobe per buffer
//   o_lb_rd_en     read-advance strobe per buffer
//   i_lb0..3_data  three adjacent pixels from each buffer (combinational)
//   o_pixel_data   3x3 window: top [9P-1:6P], mid [6P-1:3P], bottom [3P-1:0]
//   o_pixel_valid  o_pixel_data valid this cycle
//   o_intr         one-cycle pulse per fully consumed line
//   o_ovf          sticky: a pixel was written while the bank was full
//
// Build option
//   IMGCTRL_READY_EN  adds i_out_ready; reads advance only while it is high
//                     and the window is held stable with o_pixel_valid high
//                     while it is low. Undefined: downstream always ready.
// ---------------------------------------------------------------------------
module image_control #(
    parameter int IMG_WIDTH = 512,
    parameter int PIX_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [PIX_W-1:0]     i_pixel_data,
    input  logic                 i_pixel_valid,
`ifdef IMGCTRL_READY_EN
    input  logic                 i_out_ready,
`endif
    output logic [PIX_W-1:0]     o_lb_data,
    output logic [3:0]           o_lb_wr_en,
    output logic [3:0]           o_lb_rd_en,
    input  logic [3*PIX_W-1:0]   i_lb0_data,
    input  logic [3*PIX_W-1:0]   i_lb1_data,
    input  logic [3*PIX_W-1:0]   i_lb2_data,
    input  logic [3*PIX_W-1:0]   i_lb3_data,
    output logic [9*PIX_W-1:0]   o_pixel_data,
    output logic                 o_pixel_valid,
    output logic                 o_intr,
    output logic                 o_ovf
);

    localparam int CNT_W  = $clog2(IMG_WIDTH);
    localparam int FILL_W = $clog2(4 * IMG_WIDTH) + 1;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_COL  = CNT_W'(IMG_WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] START_LVL = FILL_W'(3 * IMG_WIDTH);
    localparam logic [FILL_W-1:0] FULL_LVL  = FILL_W'(4 * IMG_WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RD   = 1'b1
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  wr_cnt_r;
    logic [1:0]        wr_sel_r;
    logic [CNT_W-1:0]  rd_cnt_r;
    logic [1:0]        rd_sel_r;
    logic [FILL_W-1:0] fill_r;
    logic              intr_r;
    logic              ovf_r;

    logic              ready_s;
    logic              wr_s;
    logic              rd_active_s;
    logic              rd_s;
    logic              full_s;
    logic              valid_s;

    // Selects one buffer's three-pixel row by buffer index.
    function automatic logic [3*PIX_W-1:0] pick_row(
        input logic [1:0]         sel,
        input logic [3*PIX_W-1:0] b0,
        input logic [3*PIX_W-1:0] b1,
        input logic [3*PIX_W-1:0] b2,
        input logic [3*PIX_W-1:0] b3
    );
        logic [3*PIX_W-1:0] row;
        case (sel)
            2'd0:    row = b0;
            2'd1:    row = b1;
            2'd2:    row = b2;
            2'd3:    row = b3;
            default: row = b0;
        endcase
        return row;
    endfunction

`ifdef IMGCTRL_READY_EN
    assign ready_s = i_out_ready;
`else
    assign ready_s = 1'b1;
`endif

    assign wr_s        = i_pixel_valid;
    assign rd_active_s = (state_r == ST_RD);
    assign rd_s        = rd_active_s & ready_s;
    assign full_s      = (fill_r == FULL_LVL);

`ifdef IMGCTRL_READY_EN
    // With back-pressure the window stays presented while ready is low.
    assign valid_s = rd_active_s;
`else
    assign valid_s = rd_s;
`endif

    // Buffer strobes and window mux, all same-cycle from the current pointers.
    always_comb begin
        o_lb_data     = i_pixel_data;
        o_lb_wr_en    = 4'b0000;
        o_lb_rd_en    = 4'b0000;
        o_pixel_valid = valid_s;
        o_pixel_data  = {(9*PIX_W){1'b0}};
        if (wr_s) begin
            o_lb_wr_en = 4'b0001 << wr_sel_r;
        end else begin
            o_lb_wr_en = 4'b0000;
        end
        // The three lines being read are every buffer except rd_sel+3.
        if (rd_s) begin
            o_lb_rd_en = ~(4'b0001 << (rd_sel_r + 2'd3));
        end else begin
            o_lb_rd_en = 4'b0000;
        end
        if (valid_s) begin
            o_pixel_data = {
                pick_row(rd_sel_r,        i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data),
                pick_row(rd_sel_r + 2'd1, i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data),
                pick_row(rd_sel_r + 2'd2, i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data)
            };
        end else begin
            o_pixel_data = {(9*PIX_W){1'b0}};
        end
    end

    // Write column counter and round-robin write buffer select.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_cnt_r <= CNT_ZERO;
            wr_sel_r <= 2'd0;
        end else if (wr_s) begin
            if (wr_cnt_r == LAST_COL) begin
                wr_cnt_r <= CNT_ZERO;
                wr_sel_r <= wr_sel_r + 2'd1;
            end else begin
                wr_cnt_r <= wr_cnt_r + CNT_ONE;
            end
        end
    end

    // Bank fill level and sticky overflow; a write into a full bank still
    // lands in the buffer but cannot raise the level further.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            fill_r <= FILL_ZERO;
            ovf_r  <= 1'b0;
        end else begin
            if (wr_s && !rd_s) begin
                if (!full_s) begin
                    fill_r <= fill_r + FILL_ONE;
                end
            end else if (rd_s && !wr_s) begin
                fill_r <= fill_r - FILL_ONE;
            end
            if (wr_s && full_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Read sequencer: waits for three lines, drains one line, returns to idle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r  <= ST_IDLE;
            rd_cnt_r <= CNT_ZERO;
            rd_sel_r <= 2'd0;
            intr_r   <= 1'b0;
        end else begin
            intr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fill_r >= START_LVL) begin
                        state_r <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (rd_s) begin
                        if (rd_cnt_r == LAST_COL) begin
                            rd_cnt_r <= CNT_ZERO;
                            rd_sel_r <= rd_sel_r + 2'd1;
                            intr_r   <= 1'b1;
                            state_r  <= ST_IDLE;
                        end else begin
                            rd_cnt_r <= rd_cnt_r + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_intr = intr_r;
    assign o_ovf  = ovf_r;

endmodule

// File: tb/tb_image_control.sv
// ---------------------------------------------------------------------------
// tb_image_control
//   Self-checking bench for image_control with IMG_WIDTH=8. Contains a simple
//   model of the four external line buffers and a line/pixel-count reference
//   model that predicts every output per cycle from the stream of pixels.
// ---------------------------------------------------------------------------
module tb_image_control;

    localparam int W  = 8;
    localparam int PW = 8;

    logic               i_clk = 1'b0;
    logic               i_rstn = 1'b1;
    logic [PW-1:0]      i_pixel_data = '0;
    logic               i_pixel_valid = 1'b0;
`ifdef IMGCTRL_READY_EN
    logic               i_out_ready = 1'b1;
`endif
    logic [PW-1:0]      o_lb_data;
    logic [3:0]         o_lb_wr_en;
    logic [3:0]         o_lb_rd_en;
    logic [3*PW-1:0]    lb_out [4];
    logic [9*PW-1:0]    o_pixel_data;
    logic               o_pixel_valid;
    logic               o_intr;
    logic               o_ovf;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    image_control #(.IMG_WIDTH(W), .PIX_W(PW)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_pixel_data (i_pixel_data),
        .i_pixel_valid(i_pixel_valid),
`ifdef IMGCTRL_READY_EN
        .i_out_ready  (i_out_ready),
`endif
        .o_lb_data    (o_lb_data),
        .o_lb_wr_en   (o_lb_wr_en),
        .o_lb_rd_en   (o_lb_rd_en),
        .i_lb0_data   (lb_out[0]),
        .i_lb1_data   (lb_out[1]),
        .i_lb2_data   (lb_out[2]),
        .i_lb3_data   (lb_out[3]),
        .o_pixel_data (o_pixel_data),
        .o_pixel_valid(o_pixel_valid),
        .o_intr       (o_intr),
        .o_ovf        (o_ovf)
    );

    // External line buffers: write pointer on wr_en, read pointer on rd_en,
    // output is three adjacent pixels starting at the read pointer.
    logic [PW-1:0] lb_mem [4][W];
    int            lb_wp [4];
    int            lb_rp [4];

    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int b = 0; b < 4; b++) begin
                lb_wp[b] <= 0;
                lb_rp[b] <= 0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (o_lb_wr_en[b]) begin
                    lb_mem[b][lb_wp[b]] <= o_lb_data;
                    lb_wp[b] <= (lb_wp[b] + 1) % W;
                end
                if (o_lb_rd_en[b]) lb_rp[b] <= (lb_rp[b] + 1) % W;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            lb_out[b] = {lb_mem[b][lb_rp[b]], lb_mem[b][(lb_rp[b] + 1) % W], lb_mem[b][(lb_rp[b] + 2) % W]};
        end
    end

    // Observed output bundle: {lb_data, wr_en, rd_en, valid, intr, ovf, window}
    logic [90:0] got_v;
    logic [90:0] want_v;
    assign got_v = {o_lb_data, o_lb_wr_en, o_lb_rd_en, o_pixel_valid, o_intr, o_ovf, o_pixel_data};

    // Reference model: counts of pixels written and windows read, fill level,
    // read-in-progress flag, and every pixel ever written in stream order.
    int            m_written;
    int            m_read;
    int            m_fill;
    bit            m_reading;
    bit            m_intr;
    bit            m_ovf;
    logic [PW-1:0] m_pix [$];

    function automatic bit ready_now();
`ifdef IMGCTRL_READY_EN
        return i_out_ready;
`else
        return 1'b1;
`endif
    endfunction

    // Window for the current read: lines k..k+2, columns j..j+2 wrapping in-line.
    function automatic logic [9*PW-1:0] exp_window();
        int k, j, idx;
        logic [9*PW-1:0] w;
        k = m_read / W;
        j = m_read % W;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                idx = (k + r) * W + (j + c) % W;
                if (idx < m_pix.size()) w[(8 - (r * 3 + c)) * PW +: PW] = m_pix[idx];
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        m_written = 0;
        m_read    = 0;
        m_fill    = 0;
        m_reading = 1'b0;
        m_intr    = 1'b0;
        m_ovf     = 1'b0;
        m_pix.delete();
    endtask

    task automatic model_eval();
        bit rd, ev;
        logic [3:0] ew, er;
        logic [9*PW-1:0] ed;
        int k;
        rd = m_reading && ready_now();
        ew = i_pixel_valid ? (4'b0001 << ((m_written / W) % 4)) : 4'b0000;
        k  = m_read / W;
        er = 4'b0000;
        if (rd) for (int r = 0; r < 3; r++) er[(k + r) % 4] = 1'b1;
`ifdef IMGCTRL_READY_EN
        ev = m_reading;
`else
        ev = rd;
`endif
        ed = ev ? exp_window() : '0;
        want_v = {i_pixel_data, ew, er, ev, m_intr, m_ovf, ed};
    endtask

    task automatic model_step();
        bit wr, rd, full, start;
        wr    = i_pixel_valid;
        rd    = m_reading && ready_now();
        full  = (m_fill == 4 * W);
        start = !m_reading && (m_fill >= 3 * W);
        if (wr) begin
            m_pix.push_back(i_pixel_data);
            m_written++;
        end
        if (wr && full) m_ovf = 1'b1;
        if (wr && !rd && !full) m_fill++;
        else if (rd && !wr) m_fill--;
        m_intr = 1'b0;
        if (rd) begin
            m_read++;
            if (m_read % W == 0) begin
                m_reading = 1'b0;
                m_intr    = 1'b1;
            end
        end else if (start) begin
            m_reading = 1'b1;
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rstn        = 1'b0;
        i_pixel_valid = 1'b0;
        i_pixel_data  = '0;
`ifdef IMGCTRL_READY_EN
        i_out_ready   = 1'b1;
`endif
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        i_rstn        = 1'b0;
        i_pixel_valid = 1'b0;
        i_pixel_data  = '0;
        #1;
        checks++;
        if (got_v[82:0] !== 83'd0) begin
            errors++;
            $display("FAIL reset_async got=%h want=0", got_v[82:0]);
        end
        do_reset();
        for (int cyc = 0; cyc < 3; cyc++) begin
            #2;
            checks++;
            if (got_v[82:0] !== 83'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h want=0", cyc, got_v[82:0]);
            end
            advance();
        end
    endtask

    // 24 sequential pixels then drain; first window and interrupt timing fixed.
    task automatic test_single_frame(input string name);
        int first_v = -1, nvalid = 0, intr_at = -1, nintr = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            i_pixel_valid = (cyc < 24);
            i_pixel_data  = (cyc < 24) ? PW'(cyc) : PW'(0);
            #2;
            model_eval();
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got_v, want_v);
            end
            if (o_pixel_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    checks++;
                    if (o_pixel_data !== 72'h000102_08090a_101112) begin
                        errors++;
                        $display("FAIL %s_first_window got=%h want=00010208090a101112", name, o_pixel_data);
                    end
                end
                nvalid++;
            end
            if (o_intr) begin
                nintr++;
                intr_at = cyc;
            end
            advance();
        end
        checks++;
        if (first_v !== 25 || nvalid !== 8 || nintr !== 1 || intr_at !== 33) begin
            errors++;
            $display("FAIL %s_timing got first=%0d n=%0d intrs=%0d intr_at=%0d want 25 8 1 33", name, first_v, nvalid, nintr, intr_at);
        end
    endtask

    // Continuous 40-pixel stream; second read runs from buffer 1 with no gap in fill.
    task automatic test_stream();
        int nintr = 0, second_first = -1;
        do_reset();
        for (int cyc = 0; cyc < 60; cyc++) begin
            i_pixel_valid = (cyc < 40);
            i_pixel_data  = (cyc < 40) ? PW'(cyc) : PW'($urandom_range(0, 255));
            #2;
            model_eval();
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL stream cyc=%0d got=%h want=%h", cyc, got_v, want_v);
            end
            if (o_pixel_valid && nintr == 1 && second_first < 0) begin
                second_first = cyc;
                checks++;
                if ({o_lb_rd_en, o_pixel_data[71:64], o_pixel_data[47:40], o_pixel_data[23:16]} !== {4'b1110, 8'd8, 8'd16, 8'd24}) begin
                    errors++;
                    $display("FAIL stream_second_read got rd=%b rows=%0d/%0d/%0d want rd=1110 rows=8/16/24", o_lb_rd_en, o_pixel_data[71:64], o_pixel_data[47:40], o_pixel_data[23:16]);
                end
            end
            if (o_intr) nintr++;
            advance();
        end
        checks++;
        if (second_first !== 34 || nintr !== 3) begin
            errors++;
            $display("FAIL stream_timing got second_start=%0d intrs=%0d want 34 3", second_first, nintr);
        end
    endtask

    // Reset while four windows of a line have been read, then refill from scratch.
    task automatic test_reset_mid_line();
        int guard = 0;
        do_reset();
        for (int cyc = 0; cyc < 24; cyc++) begin
            i_pixel_valid = 1'b1;
            i_pixel_data  = PW'($urandom_range(0, 255));
            #2;
            model_eval();
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL midreset_fill cyc=%0d got=%h want=%h", cyc, got_v, want_v);
            end
            advance();
        end
        i_pixel_valid = 1'b0;
        while (m_read < 4 && guard < 40) begin
            #2;
            model_eval();
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL midreset_read cyc=%0d got=%h want=%h", guard, got_v, want_v);
            end
            advance();
            guard++;
        end
        i_rstn       = 1'b0;
        i_pixel_data = '0;
        #1;
        checks++;
        if (got_v[82:0] !== 83'd0 || m_read !== 4) begin
            errors++;
            $display("FAIL midreset_outputs got=%h reads=%0d want=0 reads=4", got_v[82:0], m_read);
        end
        do_reset();
        test_single_frame("refill");
    endtask

    // Random-gap stream of eight lines; the fourth read wraps rd_sel 3->0.
    task automatic test_wrap();
        int wrap_cycles = 0, guard = 0;
        do_reset();
        while ((m_written < 64 || m_read < 6 * W) && guard < 300) begin
            i_pixel_valid = (m_written < 64) && ($urandom_range(0, 3) != 0);
            i_pixel_data  = PW'($urandom_range(0, 255));
            #2;
            model_eval();
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL wrap cyc=%0d got=%h want=%h", guard, got_v, want_v);
            end
            if (o_pixel_valid && (m_read / W) % 4 == 3) begin
                wrap_cycles++;
                checks++;
                if (o_lb_rd_en !== 4'b1011) begin
                    errors++;
                    $display("FAIL wrap_rd_en got=%b want=1011", o_lb_rd_en);
                end
            end
            advance();
            guard++;
        end
        checks++;
        if (wrap_cycles !== W || m_read !== 6 * W) begin
            errors++;
            $display("FAIL wrap_count got cycles=%0d reads=%0d want %0d %0d", wrap_cycles, m_read, W, 6 * W);
        end
    endtask

    // Write past a full bank; overflow must set and stay set.
    task automatic test_overflow();
        int guard = 0;
        do_reset();
`ifdef IMGCTRL_READY_EN
        i_out_ready = 1'b0;
        for (int cyc = 0; cyc < 33; cyc++) begin
`else
        for (int cyc = 0; cyc < 300 && !m_ovf; cyc++) begin
`endif
            i_pixel_valid = 1'b1;
            i_pixel_data  = PW'($urandom_range(0, 255));
            #2;
            model_eval();
            checks++;
            if (got_v[90:72] !== want_v[90:72]) begin
                errors++;
                $display("FAIL overflow_ctrl cyc=%0d got=%h want=%h", cyc, got_v[90:72], want_v[90:72]);
            end
            advance();
            guard++;
        end
        i_pixel_valid = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            #2;
            checks++;
            if (o_ovf !== 1'b1) begin
                errors++;
                $display("FAIL overflow_sticky cyc=%0d got=%b want=1 after %0d writes", cyc, o_ovf, guard);
            end
            advance();
        end
    endtask

`ifdef IMGCTRL_READY_EN
    // Ready toggling 1010 during a read: eight advances and a held window.
    task automatic test_ready_toggle();
        int pulses = 0, nintr = 0;
        bit have_held = 1'b0;
        logic [9*PW-1:0] held = '0;
        do_reset();
        for (int cyc = 0; cyc < 60; cyc++) begin
            i_pixel_valid = (cyc < 24);
            i_pixel_data  = PW'($urandom_range(0, 255));
            i_out_ready   = (cyc % 2 == 0);
            #2;
            model_eval();
            checks++;
            if (got_v !== want_v) begin
                errors++;
                $display("FAIL ready cyc=%0d got=%h want=%h", cyc, got_v, want_v);
            end
            if (o_pixel_valid && have_held) begin
                checks++;
                if (o_pixel_data !== held) begin
                    errors++;
                    $display("FAIL ready_hold cyc=%0d got=%h want=%h", cyc, o_pixel_data, held);
                end
            end
            have_held = o_pixel_valid && !i_out_ready;
            held      = o_pixel_data;
            if (o_lb_rd_en !== 4'b0000) pulses++;
            if (o_intr) nintr++;
            advance();
        end
        checks++;
        if (pulses !== 8 || nintr !== 1) begin
            errors++;
            $display("FAIL ready_count got pulses=%0d intrs=%0d want 8 1", pulses, nintr);
        end
    endtask
`endif

    initial begin
        model_reset();
        #3;
        test_reset();
        do_reset();
        test_single_frame("frame");
        test_stream();
        test_reset_mid_line();
        test_wrap();
        test_overflow();
`ifdef IMGCTRL_READY_EN
        test_ready_toggle();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
